fft_sample_loader: RTL and testbench

- Upstream feeder for the 8-point FFT core (afft8).
- Accepts a stream of complex samples over a valid/ready handshake and writes each frame into the shared sample RAM in bit-reversed order.
- After the last point of a frame is written, pulses the FFT start, then holds off new input until the FFT reports done.
- Frames terminated early with in_last are zero-padded to 2**N_LOG2 points.

---
 rtl/fft_sample_loader.sv | 161 ++++++++++++++++
 tb/tb_fft_sample_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_loader.sv
// Stream-to-RAM loader for the 8-point FFT: writes each frame bit-reversed, zero-pads short frames,
// kicks the core and waits for done. Define FFT_LOADER_PRESCALE_EN to pre-scale re/im by 1/2**N_LOG2.
module fft_sample_loader #(
    parameter int unsigned N_LOG2    = 3,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        fft_start,
    input  logic        fft_done,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {FILL, WRITE, KICK, WAIT} state_t;

    state_t            state, state_next;
    logic [N_LOG2-1:0] idx, idx_next;
    logic              pad, pad_next;
    logic              in_ready_next, mem_req_next, fft_start_next, busy_next;
    logic [15:0]       mem_addr_next;
    logic [31:0]       mem_wdata_next;
    logic [7:0]        frame_cnt_next;
    logic              accept, granted;

    function automatic logic [15:0] slot_addr(input logic [N_LOG2-1:0] i);
        logic [15:0] rev;
        rev = '0;
        for (int unsigned b = 0; b < N_LOG2; b++) begin
            rev[b] = i[N_LOG2-1-b];
        end
        return BASE_ADDR + rev;
    endfunction

    function automatic logic [31:0] scale(input logic [31:0] d);
`ifdef FFT_LOADER_PRESCALE_EN
        logic signed [15:0] re;
        logic signed [15:0] im;
        re = $signed(d[31:16]) >>> N_LOG2;
        im = $signed(d[15:0]) >>> N_LOG2;
        return {re, im};
`else
        return d;
`endif
    endfunction

    assign accept  = (state == FILL) && in_valid && in_ready;
    assign granted = (state == WRITE) && mem_req && mem_gnt;
    assign mem_we  = mem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Padding keeps the FSM in WRITE, so a short frame never revisits FILL until it is complete.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept) state_next = WRITE;
            WRITE: begin
                if (granted) begin
                    if (idx == LAST_IDX) state_next = KICK;
                    else if (!pad)       state_next = FILL;
                end
            end
            KICK:    state_next = WAIT;
            WAIT:    if (fft_done) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        idx_next       = idx;
        pad_next       = pad;
        in_ready_next  = in_ready;
        mem_req_next   = mem_req;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        fft_start_next = 1'b0;
        busy_next      = busy;
        frame_cnt_next = frame_cnt;
        case (state)
            FILL: begin
                if (accept) begin
                    in_ready_next  = 1'b0;
                    mem_req_next   = 1'b1;
                    mem_addr_next  = slot_addr(idx);
                    mem_wdata_next = scale(in_data);
                    busy_next      = 1'b1;
                    if (in_last && (idx != LAST_IDX)) pad_next = 1'b1;
                end
            end
            WRITE: begin
                if (granted) begin
                    if (idx == LAST_IDX) begin
                        idx_next       = '0;
                        pad_next       = 1'b0;
                        mem_req_next   = 1'b0;
                        fft_start_next = 1'b1;
                    end else if (pad) begin
                        idx_next       = idx + 1'b1;
                        mem_addr_next  = slot_addr(idx + 1'b1);
                        mem_wdata_next = '0;
                    end else begin
                        idx_next       = idx + 1'b1;
                        mem_req_next   = 1'b0;
                        in_ready_next  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (fft_done) begin
                    frame_cnt_next = frame_cnt + 8'd1;
                    busy_next      = 1'b0;
                    in_ready_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pad       <= 1'b0;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            fft_start <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            idx       <= idx_next;
            pad       <= pad_next;
            in_ready  <= in_ready_next;
            mem_req   <= mem_req_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            fft_start <= fft_start_next;
            busy      <= busy_next;
            frame_cnt <= frame_cnt_next;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: random frames, grant stalls, spurious done, mid-frame reset.
`timescale 1ns/1ps
module tb_fft_sample_loader;

    localparam int          N_LOG2 = 3;
    localparam int          NPTS   = 8;
    localparam logic [15:0] BASE   = 16'hFFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        fft_start;
    logic        fft_done;
    logic        busy;
    logic [7:0]  frame_cnt;

    fft_sample_loader #(.N_LOG2(N_LOG2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fft_start(fft_start), .fft_done(fft_done),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  k_model = 0;
    bit  running = 0;
    bit  start_due = 0;
    bit  busy_exp = 0;
    int  frame_exp = 0;
    int  done_wait = 0;
    int  gnt_mode = 0;
    int  stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r;
        int v;
        r = 0;
        v = k;
        for (int b = 0; b < N_LOG2; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [15:0] addr_of(input int k);
        int a;
        a = (int'(BASE) + rev_idx(k)) % 65536;
        return a[15:0];
    endfunction

    function automatic logic [31:0] scaled(input logic [31:0] d);
`ifdef FFT_LOADER_PRESCALE_EN
        int re;
        int im;
        re = int'($signed(d[31:16]));
        im = int'($signed(d[15:0]));
        re = (re - (((re % NPTS) + NPTS) % NPTS)) / NPTS;
        im = (im - (((im % NPTS) + NPTS) % NPTS)) / NPTS;
        return {re[15:0], im[15:0]};
`else
        return d;
`endif
    endfunction

    function automatic void push(input int k, input logic [31:0] d);
        wr_t w;
        w.addr = addr_of(k);
        w.data = d;
        w.last = (k == NPTS - 1);
        exp_q.push_back(w);
    endfunction

    // Monitor, scoreboard and FFT-core responder
    initial begin
        bit idle;
        bit js;
        fft_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                k_model = 0; running = 0; start_due = 0; busy_exp = 0;
                frame_exp = 0; done_wait = 0; fft_done = 1'b0;
                continue;
            end
            idle = (exp_q.size() == 0) && !running && !start_due;
            js = 0;
            check("frame_cnt", frame_cnt, frame_exp[7:0]);
            check("busy", busy, busy_exp);
            check("in_ready", in_ready, idle);
            check("mem_req", mem_req, exp_q.size() != 0);
            check("mem_we", mem_we, exp_q.size() != 0);
            if (start_due || fft_start) check("fft_start", fft_start, start_due);
            if (fft_start) begin
                running = 1; js = 1;
                done_wait = $urandom_range(1, 6);
            end
            start_due = 0;
            if (exp_q.size() != 0) begin
                check("mem_addr", mem_addr, exp_q[0].addr);
                check("mem_wdata", mem_wdata, exp_q[0].data);
                if (mem_req && mem_gnt) begin
                    if (exp_q[0].last) start_due = 1;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                push(k_model, scaled(in_data));
                if (in_last && k_model < NPTS - 1) begin
                    for (int j = k_model + 1; j < NPTS; j++) push(j, 32'h0);
                    k_model = 0;
                end else begin
                    k_model = (k_model + 1) % NPTS;
                end
                busy_exp = 1;
            end
            fft_done = 1'b0;
            if (running && !js) begin
                if (done_wait <= 1) begin
                    fft_done = 1'b1;
                    running = 0;
                    frame_exp++;
                    busy_exp = 0;
                end else begin
                    done_wait--;
                end
            end else if (!running && !start_due && $urandom_range(0, 15) == 0) begin
                fft_done = 1'b1;
            end
        end
    end

    // RAM grant source: always, random, or a 5-cycle stall on the third write slot
    initial begin
        mem_gnt = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = ($urandom_range(0, 3) != 0);
                default: begin
                    if (mem_req && mem_addr == addr_of(2) && stall_cnt < 5) begin
                        mem_gnt = 1'b0;
                        stall_cnt++;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic send(input logic [31:0] d, input bit last, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = d; in_last = last;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 600) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", t);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !running && !start_due && !fft_start && in_ready) break;
            t++;
            if (t > 3000) begin
                checks++; errors++;
                $display("FAIL idle_timeout: loader not idle after %0d cycles, required idle", t);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_fft_start", fft_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'h0);
    endtask

    initial begin
        logic [31:0] d;
        int len;
        bit  lst;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        gnt_mode = 0;
        for (int k = 0; k < NPTS; k++) begin
            d = 32'h0001_0000 * k;
            send(d, k == NPTS - 1, 0);
        end
        wait_idle();

        send(32'h1111_2222, 1'b0, 0);
        send(32'h3333_4444, 1'b0, 1);
        send(32'h5555_6666, 1'b1, 0);
        wait_idle();

        gnt_mode = 2; stall_cnt = 0;
        for (int k = 0; k < NPTS; k++) send($urandom, k == NPTS - 1, 0);
        wait_idle();

        gnt_mode = 1;
        for (int k = 0; k < 4; k++) send($urandom, 1'b0, $urandom_range(0, 1));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NPTS; k++) send(32'h8000_0010 + k, k == NPTS - 1, 0);
        wait_idle();

        for (int f = 0; f < 260; f++) begin
            len = $urandom_range(1, NPTS);
            for (int k = 0; k < len; k++) begin
                d = ($urandom_range(0, 7) == 0) ? 32'h8000_0010 : $urandom;
                lst = (k == len - 1) ? ((len < NPTS) || ($urandom_range(0, 1) == 1)) : 1'b0;
                send(d, lst, $urandom_range(0, 2));
            end
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
